// File: rtl/rx_disp_pkg.sv
// Shared constants for the UART receive-and-display block.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package rx_disp_pkg;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  localparam logic [7:0] BYTE_CLEAR = 8'h1B;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

  function automatic int unsigned baud_div(int unsigned clk_hz, logic [1:0] sel);
    int unsigned baud;
    case (sel)
      2'b00:   baud = BAUD_9600;
      2'b01:   baud = BAUD_19200;
      2'b10:   baud = BAUD_57600;
      default: baud = BAUD_115200;
    endcase
    return clk_hz / baud;
  endfunction

  // One shift-add-3 iteration: BCD digits in [19:8], binary shifting out of [7:0].
  function automatic logic [19:0] dd_step(logic [19:0] w);
    logic [19:0] a;
    a = w;
    for (int i = 0; i < 3; i++)
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    return a << 1;
  endfunction

endpackage

// File: rtl/rx_disp_gen_uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, baud down-counter and frame FSM.
// state   | meaning
// S_IDLE  | line idle, baud divisor tracks choose, waiting for falling edge
// S_START | half-bit wait, then confirm start bit is still low
// S_DATA  | sample 8 data bits LSB first, one bit period apart
// S_STOP  | sample stop bit, pulse valid or frame error
module uart_rx_core
  import rx_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic [1:0] choose_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLK_HZ / BAUD_9600 + 1);

  rx_state_e     state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] div_q, div_d, cnt_q, cnt_d, div_sel;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;

  assign div_sel     = CW'(baud_div(CLK_HZ, choose_i));
  assign byte_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (state_q != S_IDLE && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        // divisor frozen from here on, so a mid-frame choose change is ignored
        div_d = div_sel;
        if (rx_prev_q && !rx_sync_q) begin
          state_d = S_START;
          cnt_d   = (div_sel >> 1) - 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = div_q - 1'b1;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          cnt_d   = div_q - 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (rx_sync_q) valid_d = 1'b1;
          else           ferr_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/rx_disp_gen.sv
// UART byte receiver driving a multiplexed 7-segment display, either as a
// hex history of recent bytes or as the last byte in decimal.
module rx_disp_gen
  import rx_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [1:0]            choose,
  input  logic                  mode,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] scan,
  output logic                  rx_valid,
  output logic                  frame_err
);

  localparam int unsigned HW = 4 * NUM_DIGITS;
  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam int unsigned SW = $clog2(SCAN_DIV + 1);

  logic [7:0]            rx_byte;
  logic                  rx_vld, rx_ferr;
  logic [HW-1:0]         hist_q, hist_d;
  logic [7:0]            last_q, last_d;
  logic                  err_q, err_d;
  logic [19:0]           work_q, work_d;
  logic [3:0]            conv_q, conv_d;
  logic [11:0]           bcd_q, bcd_d;
  logic [SW-1:0]         tick_q, tick_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] scan_q, scan_d;
  logic [3:0]            nib;
  logic [6:0]            pat;

  uart_rx_core #(.CLK_HZ(CLK_HZ)) u_rx (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx_in),
    .choose_i    (choose),
    .byte_o      (rx_byte),
    .valid_o     (rx_vld),
    .frame_err_o (rx_ferr)
  );

  assign rx_valid  = rx_vld;
  assign frame_err = rx_ferr;
  assign seg       = seg_q;
  assign scan      = scan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
      work_q <= '0;
      conv_q <= '0;
      bcd_q  <= '0;
      tick_q <= SW'(SCAN_DIV - 1);
      dig_q  <= '0;
      seg_q  <= 8'hFF;
      scan_q <= '1;
    end else begin
      hist_q <= hist_d;
      last_q <= last_d;
      err_q  <= err_d;
      work_q <= work_d;
      conv_q <= conv_d;
      bcd_q  <= bcd_d;
      tick_q <= tick_d;
      dig_q  <= dig_d;
      seg_q  <= seg_d;
      scan_q <= scan_d;
    end
  end

  always_comb begin
    nib = 4'(hist_q >> {dig_q, 2'b00});
    pat = SEG_BLANK;
    if (!mode)                                      pat = SEG_HEX[nib];
    else if (dig_q == DW'(0))                       pat = SEG_HEX[bcd_q[3:0]];
    else if (dig_q == DW'(1) && bcd_q[11:4] != '0)  pat = SEG_HEX[bcd_q[7:4]];
    else if (dig_q == DW'(2) && bcd_q[11:8] != '0)  pat = SEG_HEX[bcd_q[11:8]];
  end

  always_comb begin
    hist_d = hist_q;
    last_d = last_q;
    err_d  = err_q;
    work_d = work_q;
    conv_d = conv_q;
    bcd_d  = bcd_q;
    tick_d = tick_q - 1'b1;
    dig_d  = dig_q;
    seg_d  = seg_q;
    scan_d = scan_q;

    if (rx_ferr) err_d = 1'b1;
    if (rx_vld) begin
      err_d = 1'b0;
      if (rx_byte == BYTE_CLEAR) begin
        hist_d = '0;
        last_d = '0;
      end else begin
        hist_d = {hist_q[HW-9:0], rx_byte};
        last_d = rx_byte;
      end
      work_d = {12'd0, last_d};
      conv_d = 4'd8;
    end else if (conv_q != '0) begin
      // bcd_q keeps the previous value until the final iteration lands
      work_d = dd_step(work_q);
      conv_d = conv_q - 1'b1;
      if (conv_q == 4'd1) bcd_d = work_d[19:8];
    end

    if (tick_q == '0) begin
      tick_d = SW'(SCAN_DIV - 1);
      dig_d  = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
      scan_d = ~(NUM_DIGITS'(1) << dig_q);
      seg_d  = {~(err_q && dig_q == '0), pat};
    end
  end

endmodule

// File: tb/tb_rx_disp_gen.sv
// Bench for rx_disp_gen: directed vector table, corner-case sequences and
// random bytes checked against a byte-level display model.
module tb_rx_disp_gen;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned ND       = 6;
  localparam int unsigned SCAN_DIV = 4;
  localparam int          DIV_FAST = 434;
  localparam int          DIV_SLOW = 5208;
  localparam logic [4:0]  BL       = 5'h10;

  logic          clk = 1'b0;
  logic          rst, rx_in, mode;
  logic [1:0]    choose;
  logic [7:0]    seg;
  logic [ND-1:0] scan;
  logic          rx_valid, frame_err;

  rx_disp_gen #(.CLK_HZ(CLK_HZ), .NUM_DIGITS(ND), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .choose    (choose),
    .mode      (mode),
    .seg       (seg),
    .scan      (scan),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_ferr = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_ferr++;
  end

  // Model: history bytes (index 0 newest), last byte, error flag
  logic [7:0] m_hist [ND/2];
  logic [7:0] m_last;
  bit         m_err;

  function automatic logic [7:0] code_seg(logic [4:0] code, bit dp_on);
    logic [6:0] s;
    case (code)
      5'h0: s = 7'h40;  5'h1: s = 7'h79;  5'h2: s = 7'h24;  5'h3: s = 7'h30;
      5'h4: s = 7'h19;  5'h5: s = 7'h12;  5'h6: s = 7'h02;  5'h7: s = 7'h78;
      5'h8: s = 7'h00;  5'h9: s = 7'h10;  5'hA: s = 7'h08;  5'hB: s = 7'h03;
      5'hC: s = 7'h46;  5'hD: s = 7'h21;  5'hE: s = 7'h06;  5'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return {~dp_on, s};
  endfunction

  function automatic logic [4:0] model_code(int d, bit md);
    int v;
    if (!md) begin
      v = int'(m_hist[d/2]);
      return (d % 2 == 1) ? 5'(v / 16) : 5'(v % 16);
    end
    v = int'(m_last);
    if (d == 0) return 5'(v % 10);
    if (d == 1) return (v >= 10) ? 5'((v / 10) % 10) : BL;
    if (d == 2) return (v >= 100) ? 5'(v / 100) : BL;
    return BL;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND/2; i++) m_hist[i] = 8'h00;
    m_last = 8'h00;
    m_err  = 1'b0;
  endtask

  task automatic model_frame(logic [7:0] b, bit good);
    if (!good) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (b == 8'h1B) begin
        for (int i = 0; i < ND/2; i++) m_hist[i] = 8'h00;
        m_last = 8'h00;
      end else begin
        for (int i = ND/2 - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = b;
        m_last    = b;
      end
    end
  endtask

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(logic [7:0] b, bit good, bit swap_choose, int div);
    logic [1:0] keep;
    keep  = choose;
    rx_in = 1'b0;
    repeat (div) @(negedge clk);
    if (swap_choose) choose = ~keep;
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (div) @(negedge clk);
    end
    choose = keep;
    rx_in  = good;
    repeat (div) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic frame(string name, logic [7:0] b, bit good, bit swap_choose);
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    send(b, good, swap_choose, DIV_FAST);
    model_frame(b, good);
    check($sformatf("%s rx_valid", name), n_valid - v0, int'(good));
    check($sformatf("%s frame_err", name), n_ferr - f0, int'(!good));
  endtask

  task automatic check_disp(string name, logic [ND-1:0][4:0] codes, bit dp_on);
    logic [7:0] got [ND];
    bit         seen [ND];
    int         bad_scan;
    bad_scan = 0;
    for (int i = 0; i < ND; i++) begin
      seen[i] = 1'b0;
      got[i]  = 8'h00;
    end
    repeat (ND*SCAN_DIV + 30) @(negedge clk);
    for (int c = 0; c < 2*ND*SCAN_DIV + 4; c++) begin
      @(negedge clk);
      if ($countones(~scan) != 1) bad_scan++;
      else
        for (int i = 0; i < ND; i++)
          if (scan[i] == 1'b0) begin
            got[i]  = seg;
            seen[i] = 1'b1;
          end
    end
    check($sformatf("%s scan_onehot", name), bad_scan, 0);
    for (int i = 0; i < ND; i++) begin
      if (!seen[i]) check($sformatf("%s d%0d_scanned", name, i), 0, 1);
      else check($sformatf("%s d%0d", name, i), int'(got[i]),
                 int'(code_seg(codes[i], dp_on && i == 0)));
    end
  endtask

  typedef struct packed {
    logic [7:0]          data;
    logic                good;
    logic                md;
    logic                dp;
    logic [ND-1:0][4:0]  dig;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int               v0, f0, c;
    logic [7:0]       rb;
    bit               rgood;
    logic [ND-1:0][4:0] codes;

    vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, {5'h0, 5'h0, 5'h0, 5'h0, 5'h3, 5'hC}};
    vecs[1] = '{8'h12, 1'b1, 1'b0, 1'b0, {5'h0, 5'h0, 5'h3, 5'hC, 5'h1, 5'h2}};
    vecs[2] = '{8'h34, 1'b1, 1'b0, 1'b0, {5'h3, 5'hC, 5'h1, 5'h2, 5'h3, 5'h4}};
    vecs[3] = '{8'h56, 1'b1, 1'b0, 1'b0, {5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h6}};
    vecs[4] = '{8'h78, 1'b1, 1'b0, 1'b0, {5'h3, 5'h4, 5'h5, 5'h6, 5'h7, 5'h8}};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, {BL,   BL,   BL,   5'h2, 5'h5, 5'h5}};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 1'b0, {BL,   BL,   BL,   BL,   BL,   5'h7}};
    vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b1, {5'h7, 5'h8, 5'hF, 5'hF, 5'h0, 5'h7}};
    vecs[8] = '{8'h9E, 1'b1, 1'b0, 1'b0, {5'hF, 5'hF, 5'h0, 5'h7, 5'h9, 5'hE}};

    rst = 1'b1; rx_in = 1'b1; choose = 2'b11; mode = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset seg", int'(seg), 8'hFF);
    check("reset scan", int'(scan), 6'h3F);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    c = 0;
    while (scan == 6'h3F && c < 4*SCAN_DIV) begin
      @(negedge clk);
      c++;
    end
    check("first scan step", int'(scan), 6'b111110);

    for (int k = 0; k < 9; k++) begin
      mode = vecs[k].md;
      frame($sformatf("vec%0d", k), vecs[k].data, vecs[k].good, 1'b0);
      check_disp($sformatf("vec%0d", k), vecs[k].dig, vecs[k].dp);
    end

    // Short low glitch at 9600 baud must be rejected at the start-bit sample
    mode = 1'b0; choose = 2'b00;
    repeat (10) @(negedge clk);
    v0 = n_valid; f0 = n_ferr;
    rx_in = 1'b0;
    repeat (100) @(negedge clk);
    rx_in = 1'b1;
    repeat (DIV_SLOW) @(negedge clk);
    check("glitch rx_valid", n_valid - v0, 0);
    check("glitch frame_err", n_ferr - f0, 0);
    choose = 2'b11;
    repeat (10) @(negedge clk);
    frame("clear", 8'h1B, 1'b1, 1'b1);
    check_disp("clear", '0, 1'b0);

    // Reset during data bit 4
    v0 = n_valid; f0 = n_ferr;
    rx_in = 1'b0;
    repeat (DIV_FAST) @(negedge clk);
    rb = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      rx_in = rb[i];
      repeat (DIV_FAST) @(negedge clk);
    end
    rx_in = rb[4];
    repeat (DIV_FAST/2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst seg", int'(seg), 8'hFF);
    check("midrst scan", int'(scan), 6'h3F);
    rx_in = 1'b1;
    rst = 1'b0;
    model_reset();
    repeat (DIV_FAST*2) @(negedge clk);
    check("midrst rx_valid", n_valid - v0, 0);
    check("midrst frame_err", n_ferr - f0, 0);
    frame("post_rst", 8'h5A, 1'b1, 1'b0);
    check_disp("post_rst", {5'h0, 5'h0, 5'h0, 5'h0, 5'h5, 5'hA}, 1'b0);

    for (int k = 0; k < 3; k++) begin
      rb    = 8'($urandom);
      rgood = ($urandom_range(0, 3) != 0);
      mode  = 1'($urandom_range(0, 1));
      frame($sformatf("rand%0d", k), rb, rgood, 1'b0);
      for (int d = 0; d < ND; d++) codes[d] = model_code(d, mode);
      check_disp($sformatf("rand%0d", k), codes, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_disp_gen.md
RX_DISP_GEN -- requirements
Module: rx_disp_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 6, number of display digits (legal 4..8, even).
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000, clocks each digit stays active.
REQ-004 The block SHALL have port clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port rx_in  input  1  asynchronous UART serial line, 8N1, idle high.
REQ-007 The block SHALL have port choose  input  2  baud select: 00=9600, 01=19200, 10=57600, 11=115200.
REQ-008 The block SHALL have port mode  input  1  0=hex history, 1=decimal last byte.
REQ-009 The block SHALL have port seg  output  8  segment drive, active-low, {dp,g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port scan  output  NUM_DIGITS  digit enable, one-hot, active-low; bit 0 = rightmost digit.
REQ-011 The block SHALL have port rx_valid  output  1  one-cycle pulse per accepted byte.
REQ-012 The block SHALL have port frame_err  output  1  one-cycle pulse per rejected frame.

Function
REQ-013 The block SHALL synchronise rx_in through two flops before any use.
REQ-014 The block SHALL set bit period DIV = CLK_HZ/baud, integer-truncated, from choose; choose is latched only in IDLE.
REQ-015 The receiver SHALL run FSM IDLE->START->DATA->STOP->IDLE.
REQ-016 IDLE->START on synchronised falling edge; START SHALL sample at DIV/2, return to IDLE if high (glitch), else enter DATA.
REQ-017 DATA SHALL sample 8 bits LSB first, each DIV clocks after the previous sample.
REQ-018 STOP SHALL sample DIV clocks after bit 7; if high, byte accepted and rx_valid pulses; if low, frame_err pulses and the byte is discarded; both return to IDLE.
REQ-019 An accepted byte 0x1B SHALL clear the history buffer to zero instead of being stored; rx_valid still pulses.
REQ-020 Any other accepted byte SHALL shift into a NUM_DIGITS/2-byte history, newest byte in digits 1:0, oldest dropped.
REQ-021 The block SHALL register the last accepted byte as last_byte; a clear SHALL set it to 0.
REQ-022 In hex mode each digit SHALL show its history nibble as 0-F, all digits lit including leading zeros.
REQ-023 In decimal mode the block SHALL convert last_byte to 3 BCD digits with a sequential shift-add-3, 8 clocks after rx_valid; the previous value is held meanwhile.
REQ-024 In decimal mode digits 2:0 SHALL show hundreds/tens/units, leading zeros blanked (units always lit); digits above 2 SHALL be blank.
REQ-025 The scan counter SHALL advance one digit every SCAN_DIV clocks, wrapping from NUM_DIGITS-1 to 0.
REQ-026 seg SHALL be registered and SHALL change in the same cycle as scan, so no ghosting.
REQ-027 dp SHALL be lit on digit 0 only while frame_err has occurred since the last accepted byte.
REQ-028 A mode change SHALL take effect on the next scan step; a choose change mid-frame SHALL not affect that frame.

Reset
REQ-029 On rst high at a clock edge: FSM=IDLE, history=0, last_byte=0, BCD=0, scan counter=0, error flag=0.
REQ-030 Output reset values: seg=8'hFF, scan=all ones, rx_valid=0, frame_err=0; the first scan step after reset enables digit 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no rx_valid or frame_err pulse.

Structure
REQ-032 Package rx_disp_pkg SHALL hold the hex-to-7-seg table, the blank pattern and the four baud constants.
REQ-033 Sub-module uart_rx_core SHALL contain the synchroniser, baud counter and FSM, exporting byte, valid and frame_err.

Verification
REQ-034 Verification SHALL cover: CLK_HZ=50M, choose=11 (DIV=434), send 0x3C -> rx_valid once, digits 1:0 show 3,C, other digits 0.
REQ-035 Verification SHALL cover: hex mode, send 0x12,0x34,0x56,0x78 with NUM_DIGITS=6 -> display reads 345678.
REQ-036 Verification SHALL cover: mode=1, send 0xFF -> 255; send 0x07 -> two blanks then 7; digits 5:3 blank.
REQ-037 Verification SHALL cover: frame with stop bit low -> frame_err pulse, no rx_valid, history unchanged, dp on digit 0; a later good byte clears dp.
REQ-038 Verification SHALL cover: 100-clock low glitch on rx_in at choose=00 -> no pulses, FSM back in IDLE; then send 0x1B -> history all zeros.
REQ-039 Verification SHALL cover: rst asserted at bit 4 of a frame -> outputs at reset values, no pulse, next full frame received correctly.
